// File: rtl/round_robin_fifo_distributor.sv
// Round-robin FIFO distributor.
// A single producer stream is dealt in strict rotation A->B->C->D->A into four
// independent FIFOs. Each FIFO is drained by its own consumer. Read data are
// registered, so each channel has a one-cycle read latency.
// The rotation pointer advances on every presented word, including dropped
// ones. A full channel is never skipped; the word aimed at it is discarded.

module round_robin_fifo_distributor #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    input  logic [3:0]       ren,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       valid,
    output logic [3:0]       err,
    output logic             drop,
    output logic [3:0]       full,
    output logic [3:0]       empty,
    output logic [1:0]       next_ch
);

    localparam int AW = $clog2(DEPTH);
    // The count is one bit wider than the pointers so full and empty differ.
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Per-channel storage and bookkeeping.
    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [AW-1:0]    wr_ptr [4];
    logic [AW-1:0]    rd_ptr [4];
    logic [AW:0]      count  [4];
    logic [WIDTH-1:0] dout   [4];

    logic [3:0] push;
    logic [3:0] pop;
    logic       drop_next;

    // Decide which channel stores the incoming word and which channels pop.
    // A full channel still accepts a word when it is being read in the same
    // cycle, because the pop frees a slot at the same edge.
    always_comb begin
        push      = '0;
        pop       = '0;
        drop_next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pop[i]  = ren[i] && (count[i] != '0);
            push[i] = wen && (next_ch == 2'(i)) &&
                      ((count[i] != FULL_CNT) || ren[i]);
        end
        drop_next = wen && !push[next_ch];
    end

    // Storage write. Contents are not reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= din;
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping per channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Registered read data, valid and empty-read error flags.
    // When a full FIFO is written and read in the same cycle the pointers are
    // equal; the read still returns the old entry since the write lands later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                dout[i] <= '0;
            end
            valid <= '0;
            err   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                dout[i]  <= pop[i] ? mem[i][rd_ptr[i]] : '0;
                valid[i] <= pop[i];
                err[i]   <= ren[i] && (count[i] == '0);
            end
        end
    end

    // Rotation pointer and drop pulse; rotation advances on every presented word.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_ch <= '0;
            drop    <= 1'b0;
        end else begin
            if (wen) begin
                next_ch <= next_ch + 2'd1;
            end
            drop <= drop_next;
        end
    end

    // Status flags straight from registered occupancy.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < 4; i++) begin
            full[i]  = (count[i] == FULL_CNT);
            empty[i] = (count[i] == '0);
        end
    end

    assign a = dout[0];
    assign b = dout[1];
    assign c = dout[2];
    assign d = dout[3];

endmodule
